// File: rtl/piso_tx.sv
// piso_tx: parallel-in serial-out word transmitter with a valid/ready word input.
// Define PISO_PARITY_EN to append an even-parity bit after the data bits.
module piso_tx #(
    parameter int WIDTH      = 8,
    parameter int MSB_FIRST  = 1,
    parameter int GAP_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_in,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             busy,
    output logic             done
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
    localparam logic [3:0] GAP_LAST = 4'(GAP_CYCLES > 0 ? GAP_CYCLES - 1 : 0);

`ifdef PISO_PARITY_EN
    typedef enum logic [1:0] {IDLE, SHIFT, PARITY, GAP} state_e;
`else
    typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_e;
`endif

    state_e           state_q, state_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [3:0]       gap_q, gap_d;
    logic             sout_q, sout_d;
    logic             sval_q, sval_d;
    logic             done_q, done_d;
`ifdef PISO_PARITY_EN
    logic             par_q, par_d;
`endif

    function automatic logic head(input logic [WIDTH-1:0] w);
        return (MSB_FIRST != 0) ? w[WIDTH-1] : w[0];
    endfunction

    function automatic logic [WIDTH-1:0] adv(input logic [WIDTH-1:0] w);
        return (MSB_FIRST != 0) ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
    endfunction

    always_comb begin
        state_d = state_q;
        sh_d    = sh_q;
        cnt_d   = cnt_q;
        gap_d   = gap_q;
        sout_d  = 1'b0;
        sval_d  = 1'b0;
        done_d  = 1'b0;
`ifdef PISO_PARITY_EN
        par_d   = par_q;
`endif
        unique case (state_q)
            IDLE: begin
                // First bit is presented straight from data_in so it appears next cycle
                if (din_valid && din_ready) begin
                    sh_d    = adv(data_in);
                    cnt_d   = '0;
                    sout_d  = head(data_in);
                    sval_d  = 1'b1;
                    state_d = SHIFT;
`ifdef PISO_PARITY_EN
                    par_d   = ^data_in;
`endif
                end
            end
            SHIFT: begin
                if (cnt_q == LAST_BIT) begin
`ifdef PISO_PARITY_EN
                    sout_d  = par_q;
                    sval_d  = 1'b1;
                    state_d = PARITY;
`else
                    done_d  = 1'b1;
                    gap_d   = '0;
                    state_d = (GAP_CYCLES > 0) ? GAP : IDLE;
`endif
                end else begin
                    sout_d = head(sh_q);
                    sval_d = 1'b1;
                    sh_d   = adv(sh_q);
                    cnt_d  = cnt_q + 1'b1;
                end
            end
`ifdef PISO_PARITY_EN
            PARITY: begin
                done_d  = 1'b1;
                gap_d   = '0;
                state_d = (GAP_CYCLES > 0) ? GAP : IDLE;
            end
`endif
            GAP: begin
                if (gap_q == GAP_LAST) begin
                    state_d = IDLE;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            sh_q    <= '0;
            cnt_q   <= '0;
            gap_q   <= '0;
            sout_q  <= 1'b0;
            sval_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef PISO_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            cnt_q   <= cnt_d;
            gap_q   <= gap_d;
            sout_q  <= sout_d;
            sval_q  <= sval_d;
            done_q  <= done_d;
`ifdef PISO_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    assign din_ready = (state_q == IDLE) && rst;
    assign busy      = (state_q != IDLE);
    assign ser_out   = sout_q;
    assign ser_valid = sval_q;
    assign done      = done_q;

endmodule

// File: tb/tb_piso_tx.sv
// tb_piso_tx: scoreboard bench for piso_tx, MSB-first/gap=2 and LSB-first/gap=0.
// Honours PISO_PARITY_EN when the bench and design are built with it.
`timescale 1ns/1ps
module tb_piso_tx;

    localparam int W   = 8;
    localparam int GAP = 2;
`ifdef PISO_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif
    localparam int LAST = W + P;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [W-1:0] data_a = '0, data_b = '0;
    logic         vld_a = 1'b0, vld_b = 1'b0;
    logic         rdy_a, so_a, sv_a, busy_a, done_a;
    logic         rdy_b, so_b, sv_b, busy_b, done_b;
    logic [W-1:0] sipo_q = '0;

    int checks = 0;
    int errors = 0;
    bit exp_a[$];
    bit exp_b[$];

    always #5 clk = ~clk;

    piso_tx #(.WIDTH(W), .MSB_FIRST(1), .GAP_CYCLES(GAP)) dut_a (
        .clk(clk), .rst(rst), .data_in(data_a), .din_valid(vld_a),
        .din_ready(rdy_a), .ser_out(so_a), .ser_valid(sv_a),
        .busy(busy_a), .done(done_a)
    );

    piso_tx #(.WIDTH(W), .MSB_FIRST(0), .GAP_CYCLES(0)) dut_b (
        .clk(clk), .rst(rst), .data_in(data_b), .din_valid(vld_b),
        .din_ready(rdy_b), .ser_out(so_b), .ser_valid(sv_b),
        .busy(busy_b), .done(done_b)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input int which, input logic [W-1:0] w, input bit msb);
        bit b;
        for (int i = 0; i < W; i++) begin
            b = msb ? w[W-1-i] : w[i];
            if (which == 0) exp_a.push_back(b);
            else exp_b.push_back(b);
        end
        if (P == 1) begin
            if (which == 0) exp_a.push_back(^w);
            else exp_b.push_back(^w);
        end
    endtask

    // Behavioural 8-bit receiver: shifts ser_out in at the LSB on each load
    always @(posedge clk) if (sv_b) sipo_q <= {sipo_q[W-2:0], so_b};

    always @(negedge clk) begin
        if (rst) begin
            if (sv_a) begin
                if (exp_a.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL sbA_unexpected: got bit %0b expected none", so_a);
                end else chk("sbA_bit", so_a, exp_a.pop_front());
            end else chk("sbA_idle_zero", so_a, 0);
            if (sv_b) begin
                if (exp_b.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL sbB_unexpected: got bit %0b expected none", so_b);
                end else chk("sbB_bit", so_b, exp_b.pop_front());
            end else chk("sbB_idle_zero", so_b, 0);
        end
    end

    task automatic send_frame_a(input logic [W-1:0] w);
        data_a = w;
        vld_a  = 1'b1;
        push(0, w, 1'b1);
        @(posedge clk);
        #1 vld_a = 1'b0;
        for (int c = 1; c <= LAST + GAP + 1; c++) begin
            @(negedge clk);
            chk($sformatf("A_valid_c%0d", c), sv_a, (c <= LAST));
            chk($sformatf("A_done_c%0d", c), done_a, (c == LAST + 1));
            chk($sformatf("A_busy_c%0d", c), busy_a, (c <= LAST + GAP));
        end
        chk("A_ready_end", rdy_a, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int acc2;
        repeat (2) @(negedge clk);
        chk("rst_ser_out", so_a, 0);
        chk("rst_ser_valid", sv_a, 0);
        chk("rst_done", done_a, 0);
        chk("rst_busy", busy_a, 0);
        chk("rst_ready_a", rdy_a, 0);
        chk("rst_ready_b", rdy_b, 0);
        rst = 1'b1;
        #1 chk("ready_after_release", rdy_a, 1);

        send_frame_a(8'hF0);
`ifdef PISO_PARITY_EN
        send_frame_a(8'h07);
`endif

        // Back-to-back with din_valid held
        acc2 = LAST + GAP + 1;
        data_a = 8'hAA;
        vld_a  = 1'b1;
        push(0, 8'hAA, 1'b1);
        push(0, 8'hFF, 1'b1);
        @(posedge clk);
        for (int c = 1; c <= acc2 + LAST + 1; c++) begin
            @(negedge clk);
            if (c == 1) data_a = 8'hFF;
            chk($sformatf("B2B_valid_c%0d", c), sv_a,
                (c <= LAST) || (c > acc2 && c <= acc2 + LAST));
            if (c == acc2) chk("B2B_ready_c", rdy_a, 1);
            if (c == acc2 + 1) vld_a = 1'b0;
        end
        repeat (GAP + 1) @(negedge clk);
        chk("B2B_idle", busy_a, 0);

        // Words offered while busy are ignored
        data_a = 8'h12;
        vld_a  = 1'b1;
        push(0, 8'h12, 1'b1);
        @(posedge clk);
        #1 vld_a = 1'b0;
        for (int c = 1; c <= LAST + GAP + 3; c++) begin
            @(negedge clk);
            if (c == 3 || c == LAST + 1) begin
                data_a = 8'h3C;
                vld_a  = 1'b1;
            end
            if (c == 4 || c == LAST + 2) vld_a = 1'b0;
        end
        chk("ignore_busy_idle", busy_a, 0);
        send_frame_a(8'h5A);

        // Reset mid-frame after the third bit
        @(negedge clk);
        data_a = 8'hF0;
        vld_a  = 1'b1;
        push(0, 8'hF0, 1'b1);
        @(posedge clk);
        #1 vld_a = 1'b0;
        repeat (3) @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk("abort_ser_out", so_a, 0);
        chk("abort_ser_valid", sv_a, 0);
        chk("abort_done", done_a, 0);
        chk("abort_busy", busy_a, 0);
        chk("abort_ready", rdy_a, 0);
        chk("abort_leftover", exp_a.size(), W - 3 + P);
        exp_a.delete();
        @(negedge clk);
        rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("abort_no_done", done_a, 0);
            chk("abort_no_busy", busy_a, 0);
        end
        #1 send_frame_a(8'h55);

        // LSB-first, GAP_CYCLES=0, held valid, receiver loopback
        data_b = 8'h01;
        vld_b  = 1'b1;
        push(1, 8'h01, 1'b0);
        push(1, 8'h01, 1'b0);
        @(posedge clk);
        for (int c = 1; c <= 2 * LAST + 2; c++) begin
            @(negedge clk);
            chk($sformatf("LSB_valid_c%0d", c), sv_b,
                (c <= LAST) || (c >= LAST + 2 && c <= 2 * LAST + 1));
            chk($sformatf("LSB_done_c%0d", c), done_b,
                (c == LAST + 1) || (c == 2 * LAST + 2));
            if (c == W + 1) chk("sipo_loopback", sipo_q, 8'h80);
            if (c == LAST + 2) vld_b = 1'b0;
        end

        repeat (3) @(negedge clk);
        chk("sbA_empty", exp_a.size(), 0);
        chk("sbB_empty", exp_b.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
